counter_binner: RTL and testbench

- Time-binning front end for the counter buffer SRAM. Counts rising edges of a synchronous detector pulse over fixed-length gate windows (bins).
- Writes one count word per bin into SRAM write port A at consecutive addresses.
- Software reads the buffer through port B while acquisition continues. Port A has write priority, so this block never stalls.

---
 rtl/counter_pkg.sv | 27 ++
 rtl/counter_edge_detect.sv | 29 ++
 rtl/counter_binner.sv | 134 +++++++++++++
 tb/tb_counter_binner.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// ============================================================================
// Module   : counter_pkg
// Purpose  : Shared types and constants for the counter binning front end.
// Revision : 1.0
// ============================================================================
`default_nettype none

package counter_pkg;

    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DATA_WIDTH = 18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;
    typedef logic [DEF_DATA_WIDTH-1:0] count_t;

    // Saturation value for the default count word width.
    localparam count_t COUNT_MAX = '1;

endpackage

`default_nettype wire

// File: rtl/counter_edge_detect.sv
// ============================================================================
// Module   : counter_edge_detect
// Purpose  : Rising-edge detector; a level already high at reset is not an edge.
// Revision : 1.0
// ============================================================================
`default_nettype none

module counter_edge_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pulse,
    output logic o_edge
);

    logic r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= i_pulse;
        end
    end

    assign o_edge = i_pulse & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/counter_binner.sv
// ============================================================================
// Module   : counter_binner
// Purpose  : Counts detector edges per fixed-length bin and writes one word per
//            bin to SRAM port A at consecutive (wrapping) addresses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module counter_binner
    import counter_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 18,
    parameter int LEN_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_pulse,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic [LEN_WIDTH-1:0]  i_bin_len,
    input  logic [ADDR_WIDTH:0]   i_num_bins,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_write_enable,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overflow,
    output logic [ADDR_WIDTH:0]   o_bins_written
);

    localparam logic [DATA_WIDTH-1:0] c_count_max = '1;
    localparam logic [LEN_WIDTH-1:0]  c_len_one   = LEN_WIDTH'(1);

    state_t                  r_state;
    logic [LEN_WIDTH-1:0]    r_len;
    logic [LEN_WIDTH-1:0]    r_cycle;
    logic [ADDR_WIDTH:0]     r_nbins;
    logic [DATA_WIDTH-1:0]   r_count;
    logic [ADDR_WIDTH-1:0]   r_waddr;

    logic                    w_edge;
    logic                    w_bin_end;
    logic                    w_sat;
    logic                    w_complete;
    logic [DATA_WIDTH-1:0]   w_count_next;

    counter_edge_detect u_edge (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_pulse (i_pulse),
        .o_edge  (w_edge)
    );

    assign w_bin_end    = (r_cycle == (r_len - c_len_one));
    assign w_sat        = w_edge && (r_count == c_count_max);
    assign w_count_next = (w_edge && !w_sat) ? (r_count + 1'b1) : r_count;
    // The final write is visible on the port this cycle; finish one cycle after it.
    assign w_complete   = o_write_enable && (r_nbins != '0) && (o_bins_written == r_nbins);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= IDLE;
            r_len          <= '0;
            r_cycle        <= '0;
            r_nbins        <= '0;
            r_count        <= '0;
            r_waddr        <= '0;
            o_addr         <= '0;
            o_write_enable <= 1'b0;
            o_data         <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_overflow     <= 1'b0;
            o_bins_written <= '0;
        end else begin
            o_write_enable <= 1'b0;
            o_done         <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start && !i_stop) begin
                        r_state        <= RUN;
                        r_len          <= (i_bin_len == '0) ? c_len_one : i_bin_len;
                        r_nbins        <= i_num_bins;
                        r_cycle        <= '0;
                        r_count        <= '0;
                        r_waddr        <= '0;
                        o_addr         <= '0;
                        o_bins_written <= '0;
                        o_overflow     <= 1'b0;
                        o_busy         <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_complete) begin
                        r_state <= DONE;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                    end else begin
                        if (w_sat) begin
                            o_overflow <= 1'b1;
                        end
                        // The next bin starts on the write cycle itself: no dead time.
                        if (w_bin_end) begin
                            o_write_enable <= 1'b1;
                            o_data         <= w_count_next;
                            o_addr         <= r_waddr;
                            r_waddr        <= r_waddr + 1'b1;
                            o_bins_written <= o_bins_written + 1'b1;
                            r_cycle        <= '0;
                            r_count        <= '0;
                        end else begin
                            r_cycle <= r_cycle + 1'b1;
                            r_count <= w_count_next;
                        end
                        if (i_stop) begin
                            r_state <= IDLE;
                            o_busy  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_counter_binner.sv
// ============================================================================
// Module   : tb_counter_binner
// Purpose  : Directed self-checking bench for counter_binner (2-bit address,
//            4-bit count words so wrap and saturation are reachable quickly).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_counter_binner;

    localparam int AW = 2;
    localparam int DW = 4;
    localparam int LW = 32;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_pulse = 1'b0;
    logic          i_start = 1'b0;
    logic          i_stop = 1'b0;
    logic [LW-1:0] i_bin_len = '0;
    logic [AW:0]   i_num_bins = '0;
    logic [AW-1:0] o_addr;
    logic          o_write_enable;
    logic [DW-1:0] o_data;
    logic          o_busy;
    logic          o_done;
    logic          o_overflow;
    logic [AW:0]   o_bins_written;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    counter_binner #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_pulse        (i_pulse),
        .i_start        (i_start),
        .i_stop         (i_stop),
        .i_bin_len      (i_bin_len),
        .i_num_bins     (i_num_bins),
        .o_addr         (o_addr),
        .o_write_enable (o_write_enable),
        .o_data         (o_data),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_overflow     (o_overflow),
        .o_bins_written (o_bins_written)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_run(input int len, input int nb);
        i_bin_len  = LW'(len);
        i_num_bins = (AW+1)'(nb);
        i_start    = 1'b1;
        tick();
        i_start    = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if ({o_write_enable, o_busy, o_done, o_overflow} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {o_write_enable, o_busy, o_done, o_overflow});
        end
        checks++;
        if ({o_addr, o_data, o_bins_written} !== '0) begin
            errors++;
            $display("FAIL reset_words: got addr %0d data %0d bins %0d expected all 0", o_addr, o_data, o_bins_written);
        end
        i_rst = 1'b0;
        tick();
    endtask

    // len=10, nbins=3: 4 edges, 0 edges, 5 edges (toggling, max possible in 10 cycles)
    task automatic test_basic();
        logic [DW-1:0] exp_data [3];
        logic          exp_we;
        exp_data[0] = 4'd4;
        exp_data[1] = 4'd0;
        exp_data[2] = 4'd5;
        i_pulse = 1'b0;
        start_run(10, 3);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_start: got %b expected 1", o_busy);
        end
        for (int k = 1; k <= 32; k++) begin
            i_pulse = (k <= 30) && (((k-1) % 2) == 0) && ((k-1) < 8 || (k-1) >= 20);
            tick();
            exp_we = (k == 10) || (k == 20) || (k == 30);
            checks++;
            if (o_write_enable !== exp_we) begin
                errors++;
                $display("FAIL basic_we k=%0d: got %b expected %b", k, o_write_enable, exp_we);
            end
            if (exp_we) begin
                checks++;
                if (o_addr !== AW'(k/10 - 1) || o_data !== exp_data[k/10 - 1]) begin
                    errors++;
                    $display("FAIL basic_word k=%0d: got addr %0d data %0d expected addr %0d data %0d",
                             k, o_addr, o_data, k/10 - 1, exp_data[k/10 - 1]);
                end
            end
            checks++;
            if (o_done !== (k == 31) || o_busy !== (k <= 30)) begin
                errors++;
                $display("FAIL basic_done_busy k=%0d: got done %b busy %b expected done %b busy %b",
                         k, o_done, o_busy, (k == 31), (k <= 30));
            end
        end
        checks++;
        if (o_bins_written !== 3'd3) begin
            errors++;
            $display("FAIL basic_bins_written: got %0d expected 3", o_bins_written);
        end
    endtask

    // len=1: a word every cycle, pulse 0,1,0,1 gives data 0,1,0,1
    task automatic test_len_one();
        logic exp_bit;
        i_pulse = 1'b0;
        start_run(1, 4);
        for (int k = 1; k <= 6; k++) begin
            i_pulse = (k == 2) || (k == 4);
            tick();
            exp_bit = (k == 2) || (k == 4);
            checks++;
            if (o_write_enable !== (k <= 4)) begin
                errors++;
                $display("FAIL len1_we k=%0d: got %b expected %b", k, o_write_enable, (k <= 4));
            end
            if (k <= 4) begin
                checks++;
                if (o_addr !== AW'(k-1) || o_data !== DW'(exp_bit)) begin
                    errors++;
                    $display("FAIL len1_word k=%0d: got addr %0d data %0d expected addr %0d data %0d",
                             k, o_addr, o_data, k-1, exp_bit);
                end
            end
            checks++;
            if (o_done !== (k == 5)) begin
                errors++;
                $display("FAIL len1_done k=%0d: got %b expected %b", k, o_done, (k == 5));
            end
        end
        i_pulse = 1'b0;
    endtask

    // len=40 with 20 edges saturates a 4-bit word; 16th edge arrives at cycle 31
    task automatic test_overflow();
        i_pulse = 1'b0;
        start_run(40, 1);
        for (int k = 1; k <= 41; k++) begin
            i_pulse = (k <= 40) && ((k % 2) == 1);
            tick();
            checks++;
            if (o_overflow !== (k >= 31)) begin
                errors++;
                $display("FAIL ovf_flag k=%0d: got %b expected %b", k, o_overflow, (k >= 31));
            end
            if (k == 40) begin
                checks++;
                if (o_write_enable !== 1'b1 || o_data !== 4'd15 || o_addr !== 2'd0) begin
                    errors++;
                    $display("FAIL ovf_word: got we %b data %0d addr %0d expected we 1 data 15 addr 0",
                             o_write_enable, o_data, o_addr);
                end
            end
            if (k == 41) begin
                checks++;
                if (o_done !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_done: got %b expected 1", o_done);
                end
            end
        end
        i_pulse = 1'b0;
        tick();
        tick();
        checks++;
        if (o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky_idle: got %b expected 1", o_overflow);
        end
        start_run(2, 1);
        checks++;
        if (o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear_on_start: got %b expected 0", o_overflow);
        end
        tick();
        tick();
        checks++;
        if (o_write_enable !== 1'b1 || o_data !== 4'd0) begin
            errors++;
            $display("FAIL ovf_next_run_word: got we %b data %0d expected we 1 data 0", o_write_enable, o_data);
        end
        tick();
        tick();
    endtask

    // nbins=0, len=2: address wraps 0..3,0,1; stop mid-bin discards the partial bin
    task automatic test_continuous();
        i_pulse = 1'b0;
        start_run(2, 0);
        for (int k = 1; k <= 12; k++) begin
            i_pulse = ((k % 2) == 1);
            tick();
            if ((k % 2) == 0) begin
                checks++;
                if (o_write_enable !== 1'b1 || o_addr !== AW'((k/2 - 1) % 4) || o_data !== 4'd1
                    || o_bins_written !== (AW+1)'(k/2)) begin
                    errors++;
                    $display("FAIL cont_word k=%0d: got we %b addr %0d data %0d bins %0d expected we 1 addr %0d data 1 bins %0d",
                             k, o_write_enable, o_addr, o_data, o_bins_written, (k/2 - 1) % 4, k/2);
                end
            end
        end
        i_pulse = 1'b1;
        i_stop  = 1'b1;
        tick();
        i_stop  = 1'b0;
        i_pulse = 1'b0;
        checks++;
        if (o_write_enable !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_bins_written !== 3'd6) begin
            errors++;
            $display("FAIL cont_stop: got we %b busy %b done %b bins %0d expected we 0 busy 0 done 0 bins 6",
                     o_write_enable, o_busy, o_done, o_bins_written);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (o_write_enable !== 1'b0 || o_done !== 1'b0) begin
                errors++;
                $display("FAIL cont_after_stop k=%0d: got we %b done %b expected 0 0", k, o_write_enable, o_done);
            end
        end
        // stop on the bin-final cycle still writes that bin
        start_run(2, 0);
        tick();
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        checks++;
        if (o_write_enable !== 1'b1 || o_addr !== 2'd0 || o_busy !== 1'b0 || o_bins_written !== 3'd1) begin
            errors++;
            $display("FAIL cont_stop_final: got we %b addr %0d busy %b bins %0d expected we 1 addr 0 busy 0 bins 1",
                     o_write_enable, o_addr, o_busy, o_bins_written);
        end
        tick();
        checks++;
        if (o_write_enable !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL cont_stop_final_after: got we %b done %b expected 0 0", o_write_enable, o_done);
        end
    endtask

    // Pulse held high across reset and start; start with stop is ignored
    task automatic test_pulse_through_reset();
        logic seen_activity;
        i_pulse = 1'b1;
        i_rst   = 1'b1;
        tick();
        i_rst   = 1'b0;
        start_run(3, 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 3) begin
                checks++;
                if (o_write_enable !== 1'b1 || o_data !== 4'd0) begin
                    errors++;
                    $display("FAIL held_pulse_word: got we %b data %0d expected we 1 data 0", o_write_enable, o_data);
                end
            end
        end
        checks++;
        if (o_done !== 1'b1) begin
            errors++;
            $display("FAIL held_pulse_done: got %b expected 1", o_done);
        end
        i_pulse = 1'b0;
        tick();
        i_start = 1'b1;
        i_stop  = 1'b1;
        tick();
        i_start = 1'b0;
        i_stop  = 1'b0;
        seen_activity = o_busy;
        for (int k = 0; k < 4; k++) begin
            tick();
            seen_activity = seen_activity | o_busy | o_write_enable;
        end
        checks++;
        if (seen_activity !== 1'b0) begin
            errors++;
            $display("FAIL start_stop_idle: got activity %b expected 0", seen_activity);
        end
    endtask

    // Reset asserted between edges mid-run clears outputs at once
    task automatic test_async_reset();
        i_pulse = 1'b0;
        start_run(1, 0);
        for (int k = 1; k <= 3; k++) begin
            i_pulse = ((k % 2) == 1);
            tick();
        end
        i_pulse = 1'b0;
        checks++;
        if (o_write_enable !== 1'b1 || o_addr !== 2'd2 || o_data !== 4'd1 || o_busy !== 1'b1 || o_bins_written !== 3'd3) begin
            errors++;
            $display("FAIL arst_pre: got we %b addr %0d data %0d busy %b bins %0d expected we 1 addr 2 data 1 busy 1 bins 3",
                     o_write_enable, o_addr, o_data, o_busy, o_bins_written);
        end
        #2;
        i_rst = 1'b1;
        #1;
        checks++;
        if ({o_write_enable, o_busy, o_done, o_overflow} !== 4'b0000
            || {o_addr, o_data, o_bins_written} !== '0) begin
            errors++;
            $display("FAIL arst_immediate: got we %b busy %b done %b ovf %b addr %0d data %0d bins %0d expected all 0",
                     o_write_enable, o_busy, o_done, o_overflow, o_addr, o_data, o_bins_written);
        end
        #3;
        i_rst = 1'b0;
        tick();
        start_run(1, 1);
        tick();
        checks++;
        if (o_write_enable !== 1'b1 || o_addr !== 2'd0 || o_data !== 4'd0 || o_bins_written !== 3'd1) begin
            errors++;
            $display("FAIL arst_restart: got we %b addr %0d data %0d bins %0d expected we 1 addr 0 data 0 bins 1",
                     o_write_enable, o_addr, o_data, o_bins_written);
        end
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        tick();
        test_len_one();
        tick();
        test_overflow();
        tick();
        test_continuous();
        tick();
        test_pulse_through_reset();
        tick();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
